// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block type, round-count constants, FSM states and GF(2^8) helpers
package aes_pkg;

  typedef logic [127:0] block_t;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES encryption round; last skips MixColumns
module aes_round
  import aes_pkg::*;
(
  input  block_t state_in,
  input  block_t round_key,
  input  logic   last,
  output block_t state_out
);

  // Byte i of the block sits at bits 127-8i; row = i%4, column = i/4.
  logic [7:0] sub_b   [16];
  logic [7:0] shift_b [16];
  logic [7:0] mix_b   [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sub_b[i] = sbox(state_in[127-8*i -: 8]);
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_b[4*c+r] = sub_b[4*((c+r)%4)+r];
      end
    end
  end

  // 2*a0 ^ 3*a1 folds into 2*(a0^a1) ^ a1, saving one doubling per byte.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mix_b[4*c+r] = gf_mul2(shift_b[4*c+r] ^ shift_b[4*c+(r+1)%4])
                     ^ shift_b[4*c+(r+1)%4]
                     ^ shift_b[4*c+(r+2)%4]
                     ^ shift_b[4*c+(r+3)%4];
      end
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (last ? shift_b[i] : mix_b[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES encryptor, UNROLL rounds per clock with valid/ready on both sides
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR     = 14,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  block_t            data_in,
  input  logic [NR:0][127:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output block_t            data_out,
  output logic              busy
);

  localparam int ITERS = NR / UNROLL;
  localparam int RW    = $clog2(NR + 1);

  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("aes_encrypt_iter: NR must be 10, 12 or 14");
  end
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("aes_encrypt_iter: UNROLL must be 1 or 2");
  end

  state_t        state;
  logic [RW-1:0] rnd;
  block_t        state_reg;
  logic          accept;
  block_t        chain [UNROLL+1];

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign data_out = state_reg;
  assign chain[0] = state_reg;

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [RW-1:0] ridx;
    assign ridx = rnd + RW'(u);
    aes_round u_round (
      .state_in  (chain[u]),
      .round_key (key[ridx]),
      .last      (ridx == RW'(NR)),
      .state_out (chain[u+1])
    );
  end

  // rnd returns to 0 on leaving RUN so it never exceeds NR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= data_in ^ key[0];
            rnd       <= RW'(1);
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= chain[UNROLL];
          if (rnd == RW'(NR - UNROLL + 1)) begin
            rnd       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rnd <= rnd + RW'(UNROLL);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state_reg <= data_in ^ key[0];
              rnd       <= RW'(1);
              state     <= RUN;
              busy      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rnd       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - four-configuration bench against a byte-matrix AES reference model
`timescale 1ns/1ps
module tb_aes_encrypt_iter;

  localparam int NCFG = 4;

  function automatic int nr_of(input int g);
    return (g == 0) ? 10 : (g == 1) ? 12 : 14;
  endfunction
  function automatic int un_of(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               out_ready;
  logic [127:0]       data_in;
  logic [14:0][127:0] keys      [NCFG];
  logic               in_ready  [NCFG];
  logic               out_valid [NCFG];
  logic               busy      [NCFG];
  logic [127:0]       data_out  [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NRG = nr_of(g);
    localparam int UG  = un_of(g);
    aes_encrypt_iter #(.NR(NRG), .UNROLL(UG)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .data_in   (data_in),
      .key       (keys[g][NRG:0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cfg%0d: got %h, expected %h", name, g, act, exp);
    end
  endtask

  // Reference AES: S-box derived from the GF(2^8) inverse plus affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // k is left-aligned: a 128-bit key occupies k[255:128].
  function automatic logic [14:0][127:0] expand(input logic [255:0] k, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [14:0][127:0] r;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [14:0][127:0] rk, input int nr);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] ct;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rd == nr) ? t[r][c]
                  : gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ rk[rd][127-8*(4*c+r) -: 8];
    end
    ct = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] exp_ct  [NCFG] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                   128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                   128'h8ea2b7ca516745bfeafc49904b496089,
                                   128'h8ea2b7ca516745bfeafc49904b496089};
  int           exp_lat [NCFG] = '{10, 12, 14, 7};

  function automatic logic [255:0] key_of(input int g);
    if (g == 0) return {K256[255:128], 128'h0};
    if (g == 1) return {K256[255:64], 64'h0};
    return K256;
  endfunction

  // Cycle model per configuration: rounds left, pending result, presented result.
  int           m_left   [NCFG];
  bit           m_valid  [NCFG];
  bit           m_zero   [NCFG];
  logic [127:0] m_data   [NCFG];
  logic [127:0] m_pend   [NCFG];
  bit           first_acc  [NCFG];
  bit           first_seen [NCFG];
  logic [127:0] first_ct   [NCFG];
  int           acc_cyc    [NCFG];
  int           lat        [NCFG];
  int           busy_cnt   [NCFG];
  int           score_acc  [NCFG];
  int           score_ret  [NCFG];
  bit           score_en = 1'b0;
  int           cyc = 0;

  initial begin
    for (int g = 0; g < NCFG; g++) begin
      m_left[g] = 0; m_valid[g] = 0; m_zero[g] = 1; m_data[g] = '0; m_pend[g] = '0;
      first_acc[g] = 0; first_seen[g] = 0; first_ct[g] = '0; acc_cyc[g] = 0;
      lat[g] = -1; busy_cnt[g] = 0; score_acc[g] = 0; score_ret[g] = 0;
    end
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      for (int g = 0; g < NCFG; g++) begin
        logic exp_rdy;
        logic acc_m;
        if (rst) begin
          m_left[g] = 0; m_valid[g] = 0; m_zero[g] = 1;
        end
        exp_rdy = !rst && ((m_left[g] == 0 && !m_valid[g]) || (m_valid[g] && out_ready));
        chk("in_ready", g, 128'(in_ready[g]), 128'(exp_rdy));
        chk("out_valid", g, 128'(out_valid[g]), 128'(m_valid[g]));
        chk("busy", g, 128'(busy[g]), 128'(m_left[g] > 0));
        if (m_valid[g] || m_zero[g])
          chk("data_out", g, data_out[g], m_valid[g] ? m_data[g] : 128'h0);
        if (first_acc[g] && !first_seen[g]) begin
          if (busy[g]) busy_cnt[g]++;
          if (out_valid[g]) begin
            first_seen[g] = 1; first_ct[g] = data_out[g]; lat[g] = cyc - acc_cyc[g];
          end
        end
        if (!rst) begin
          if (in_valid && in_ready[g]) begin
            if (!first_acc[g]) begin first_acc[g] = 1; acc_cyc[g] = cyc + 1; end
            if (score_en) score_acc[g]++;
          end
          if (out_valid[g] && out_ready && score_en) score_ret[g]++;
          acc_m = in_valid && exp_rdy;
          if (m_valid[g] && out_ready) m_valid[g] = 0;
          if (m_left[g] > 0) begin
            m_left[g]--;
            if (m_left[g] == 0) begin m_valid[g] = 1; m_data[g] = m_pend[g]; end
          end
          if (acc_m) begin
            m_pend[g] = aes_ref(data_in, keys[g], nr_of(g));
            m_left[g] = nr_of(g) / un_of(g);
            m_zero[g] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] probe;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_math(8'(i));
    for (int g = 0; g < NCFG; g++) keys[g] = expand(key_of(g), nr_of(g));

    probe = 8'h53;
    chk("model_sbox_53", 0, 128'(sb[probe]), 128'hed);
    for (int g = 0; g < 3; g++)
      chk("model_fips", g, aes_ref(PT, keys[g], nr_of(g)), exp_ct[g]);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS vectors through every configuration, no backpressure
    data_in = PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom};
    repeat (18) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk("fips_ct", g, first_ct[g], exp_ct[g]);
      chk("latency", g, 128'(lat[g]), 128'(exp_lat[g]));
      chk("busy_cycles", g, 128'(busy_cnt[g]), 128'(exp_lat[g]));
    end

    // backpressure hold, then same-edge retire and accept
    out_ready = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    data_in = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);

    // reset in the middle of a run, then a fresh block
    data_in = PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_in = PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);

    // random traffic with a handshake scoreboard
    score_en = 1'b1;
    for (int i = 0; i < 6000 && score_acc[2] < 100; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("accepted_blocks", 2, 128'(score_acc[2] >= 100), 128'(1));
    for (int g = 0; g < NCFG; g++)
      chk("accept_vs_retire", g, 128'(score_ret[g]), 128'(score_acc[g]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Parametrised iterative AES encryptor; successor to the fixed 14-round combinational pipe.
- Supports AES-128, AES-192 and AES-256 round counts.
- Executes UNROLL rounds per clock on one registered state, with valid/ready handshakes on both input and output, including output backpressure.
- Sits between the key-schedule block, which supplies the expanded round keys, and the cipher-mode datapath.

Parameters:
- NR, 14, number of AES rounds; legal values 10, 12, 14; elaboration error otherwise.
- UNROLL, 1, rounds evaluated per clock; legal values 1, 2 (NR % UNROLL == 0 always holds).
- ITERS, NR/UNROLL, derived localparam; number of round clocks per block.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  data_in and key are valid.
- in_ready  output  1  block can accept a new plaintext.
- data_in  input  128  plaintext, AES byte order (byte 0 = bits 127:120).
- key  input  128 x (NR+1)  expanded round keys; key[0] is the initial AddRoundKey key.
- out_valid  output  1  data_out holds a finished ciphertext.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  128  ciphertext.
- busy  output  1  rounds in progress (state RUN).

Behaviour:
- Reset (rst high, async): state=IDLE, round counter=0, state register=0.
  - Outputs during and after reset: out_valid=0, data_out=0, busy=0, in_ready=0 while rst is high.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: state_reg <= data_in ^ key[0]; rnd <= 1; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge applies UNROLL rounds using key[rnd] .. key[rnd+UNROLL-1]; rnd += UNROLL.
  - Rounds 1..NR-1 are full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey).
  - Round NR omits MixColumns.
  - With UNROLL=2, the second round of the final pair is the last round.
  - After the edge that applies round NR (edge E0+ITERS), go to DONE.
- DONE:
  - out_valid=1; data_out=state_reg, held stable until the handshake.
  - in_ready = out_ready.
  - Edge with out_ready=1 and in_valid=0: go to IDLE; out_valid=0 next cycle.
  - Edge with out_ready=1 and in_valid=1: simultaneous retire and accept; load the new block as in IDLE and go to RUN.
  - Edge with out_ready=0: hold everything; no data loss and no change to data_out.
- Latency:
  - out_valid rises in the cycle after edge E0+ITERS (14 clocks for NR=14, UNROLL=1; 5 for NR=10, UNROLL=2).
  - Back-to-back throughput is one block per ITERS+1 clocks.
- Key stability: key is not registered. Upstream holds key constant from the accepting edge until out_valid; the key-schedule block guarantees this. Changing key mid-RUN is a protocol violation with undefined ciphertext.
- data_in is only sampled at the accepting edge.
- in_valid while in_ready=0 has no effect; the upstream holds the request.
- Reset asserted mid-RUN or mid-DONE aborts the block immediately; no partial output is ever presented.
- Round counter width is clog2(NR+1); it never exceeds NR.
- out_valid and data_out come directly from registers; in_ready is combinational only from state and out_ready.

Decomposition:
- aes_pkg holds:
  - block_t (logic [127:0]);
  - the S-box function;
  - xtime/gf_mul2 function;
  - NR_AES128/NR_AES192/NR_AES256 constants (10/12/14);
  - state enum {IDLE, RUN, DONE}.
- Sub-module aes_round: combinational single round with ports state_in, round_key, last (skips MixColumns), state_out. Instantiate UNROLL copies chained.

Test Plan:
1. NR=10, UNROLL=1; data_in=00112233445566778899aabbccddeeff; FIPS-197 expansion of key 000102030405060708090a0b0c0d0e0f; out_ready=1 -> out_valid exactly 10 clocks after accept, data_out=69c4e0d86a7b0430d8cdb78070b4c55a, busy high 10 cycles.
2. NR=12 with the 192-bit key 00..17, and NR=14 with the 256-bit key 00..1f, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 respectively; latencies 12 and 14.
3. NR=14, UNROLL=2 -> same 8ea2… result after 7 clocks.
4. Backpressure: out_ready=0 for 20 cycles after out_valid -> data_out and out_valid constant, in_ready=0. Then out_ready=1 together with a second in_valid -> same-edge retire and accept; second result correct ITERS clocks later.
5. Assert rst for 1 cycle at round 5 of an NR=14 run -> out_valid=0 and data_out=0 immediately. After release in_ready=1, and a fresh block encrypts correctly.
6. in_valid pulsed during RUN -> ignored; exactly one output per accepted handshake (scoreboard count match over 100 random blocks against the reference model).
